dot_product_sequencer: RTL and testbench



---
 rtl/dpseq_pkg.sv | 17 +
 rtl/dpseq_watchdog.sv | 32 +++
 rtl/dot_product_sequencer.sv | 131 +++++++++++++
 tb/tb_dot_product_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dpseq_pkg.sv
// Shared types and defaults for the dot-product sequencer.
package dpseq_pkg;

   localparam int unsigned RESULT_W        = 16;
   localparam int unsigned DEF_VEC_LEN     = 4;
   localparam int unsigned DEF_TIMEOUT_CYC = 255;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_LOAD = 3'd1,
      S_ARM       = 3'd2,
      S_STREAM    = 3'd3,
      S_WAIT_COMP = 3'd4,
      S_DONE      = 3'd5
   } dpseq_state_e;

endpackage

// File: rtl/dpseq_watchdog.sv
// Wait-state timeout counter; only instantiated when DPSEQ_TIMEOUT_EN is defined.
module dpseq_watchdog
   import dpseq_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] count;

   // Expires on the TIMEOUT_CYC-th cycle spent in a wait state, so the FSM
   // leaves exactly TIMEOUT_CYC cycles after entry.
   assign expire = enable && (count == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expire) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/dot_product_sequencer.sv
// Sequences vector load, compute start, element streaming and result handoff.
// Optional wait-state watchdog is compiled in with DPSEQ_TIMEOUT_EN.
module dot_product_sequencer
   import dpseq_pkg::*;
#(
   parameter int unsigned VEC_LEN     = DEF_VEC_LEN,
   parameter int unsigned IDX_W       = 8,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                GO,
   input  logic                ABORT,
   input  logic                ACK,
   input  logic                doneA,
   input  logic                doneB,
   input  logic                comp_done,
   input  logic [RESULT_W-1:0] dot_result,
   output logic                RD_EN,
   output logic                START_COMP,
   output logic [IDX_W-1:0]    ELEM_IDX,
   output logic                BUSY,
   output logic [RESULT_W-1:0] RESULT,
   output logic                RESULT_VALID,
   output logic                ERR
);

   if (VEC_LEN < 1 || VEC_LEN > 255 || TIMEOUT_CYC < 1 ||
       (64'(1) << IDX_W) < 64'(VEC_LEN)) begin : g_bad_params
      $error("dot_product_sequencer: illegal parameter set");
   end

   dpseq_state_e state, state_nx;
   logic         timeout;
   logic         go_accept;
   logic         latch_result;
   logic         err_set;
   logic         last_idx;

`ifdef DPSEQ_TIMEOUT_EN
   logic in_wait;

   assign in_wait = (state == S_WAIT_LOAD) || (state == S_WAIT_COMP);

   dpseq_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk    (CLK),
      .rst_n  (RST_N),
      .clear  (!in_wait),
      .enable (in_wait),
      .expire (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   assign last_idx = (ELEM_IDX == IDX_W'(VEC_LEN - 1));

   // A real completion event wins over a watchdog expiry in the same cycle.
   always_comb begin
      state_nx     = state;
      go_accept    = 1'b0;
      latch_result = 1'b0;
      err_set      = 1'b0;
      if (ABORT) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (GO) begin
                  go_accept = 1'b1;
                  state_nx  = (doneA && doneB) ? S_ARM : S_WAIT_LOAD;
               end
            end
            S_WAIT_LOAD: begin
               if (doneA && doneB) begin
                  state_nx = S_ARM;
               end else if (timeout) begin
                  err_set  = 1'b1;
                  state_nx = S_IDLE;
               end
            end
            S_ARM:    state_nx = S_STREAM;
            S_STREAM: if (last_idx) state_nx = S_WAIT_COMP;
            S_WAIT_COMP: begin
               if (comp_done) begin
                  latch_result = 1'b1;
                  state_nx     = S_DONE;
               end else if (timeout) begin
                  err_set  = 1'b1;
                  state_nx = S_IDLE;
               end
            end
            S_DONE:   if (ACK) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state        <= S_IDLE;
         RD_EN        <= 1'b0;
         START_COMP   <= 1'b0;
         ELEM_IDX     <= '0;
         BUSY         <= 1'b0;
         RESULT       <= '0;
         RESULT_VALID <= 1'b0;
         ERR          <= 1'b0;
      end else begin
         state        <= state_nx;
         START_COMP   <= (state_nx == S_ARM);
         RD_EN        <= (state_nx == S_STREAM);
         ELEM_IDX     <= (state == S_STREAM && state_nx == S_STREAM) ?
                         ELEM_IDX + 1'b1 : '0;
         BUSY         <= !(state_nx == S_IDLE || state_nx == S_DONE);
         RESULT_VALID <= (state_nx == S_DONE);
         if (latch_result) begin
            RESULT <= dot_result;
         end
         if (err_set) begin
            ERR <= 1'b1;
         end else if (go_accept) begin
            ERR <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench for dot_product_sequencer: directed scenarios plus
// randomized runs predicted from a per-run event timeline.
module tb_dot_product_sequencer;

   localparam int N = 4;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        GO = 1'b0;
   logic        ABORT = 1'b0;
   logic        ACK = 1'b0;
   logic        doneA = 1'b0;
   logic        doneB = 1'b0;
   logic        comp_done = 1'b0;
   logic [15:0] dot_result = '0;
   logic        RD_EN;
   logic        START_COMP;
   logic [7:0]  ELEM_IDX;
   logic        BUSY;
   logic [15:0] RESULT;
   logic        RESULT_VALID;
   logic        ERR;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic [15:0] model_result = '0;
   logic        model_err    = 1'b0;

   dot_product_sequencer #(
      .VEC_LEN     (N),
      .IDX_W       (8),
      .TIMEOUT_CYC (8)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .GO           (GO),
      .ABORT        (ABORT),
      .ACK          (ACK),
      .doneA        (doneA),
      .doneB        (doneB),
      .comp_done    (comp_done),
      .dot_result   (dot_result),
      .RD_EN        (RD_EN),
      .START_COMP   (START_COMP),
      .ELEM_IDX     (ELEM_IDX),
      .BUSY         (BUSY),
      .RESULT       (RESULT),
      .RESULT_VALID (RESULT_VALID),
      .ERR          (ERR)
   );

   always #5 CLK = ~CLK;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic check_all(input string tag, input bit e_start, input bit e_rd,
                            input int e_idx, input bit e_busy, input bit e_valid,
                            input logic [15:0] e_res, input bit e_err);
      check({tag, " START_COMP"},   32'(START_COMP),   32'(e_start));
      check({tag, " RD_EN"},        32'(RD_EN),        32'(e_rd));
      check({tag, " ELEM_IDX"},     32'(ELEM_IDX),     32'(e_idx));
      check({tag, " BUSY"},         32'(BUSY),         32'(e_busy));
      check({tag, " RESULT_VALID"}, 32'(RESULT_VALID), 32'(e_valid));
      check({tag, " RESULT"},       32'(RESULT),       32'(e_res));
      check({tag, " ERR"},          32'(ERR),          32'(e_err));
   endtask

   // One run with GO at t=0. Vectors ready from cycle r, comp_done at cycle c,
   // ACK at cycle a, ABORT at cycle x (x<0: none). Outputs observed in cycle t
   // are predicted from those event times alone.
   task automatic run_seq(input string name, input int r, input int c, input int a,
                          input int x, input bit noise, input bit go_ack, input bit level_cd);
      int          arm;
      int          end_t;
      bit          latch_ok;
      bit          ab;
      bit          e_rd;
      logic [15:0] new_res;
      logic [1:0]  partial;
      arm      = r + 1;
      end_t    = ((a > c) ? a : c) + 3;
      latch_ok = (x < 0) || (c < x);
      new_res  = '0;
      for (int t = 0; t <= end_t; t++) begin
         @(negedge CLK);
         ab   = (x >= 0) && (t > x);
         e_rd = !ab && t >= arm + 1 && t <= arm + N;
         check_all($sformatf("%s t%0d", name, t),
                   !ab && t == arm,
                   e_rd,
                   e_rd ? t - arm - 1 : 0,
                   !ab && t >= 1 && t <= c,
                   !ab && t >= c + 1 && t <= a,
                   (latch_ok && t >= c + 1) ? new_res : model_result,
                   (t == 0 || x == 0) ? model_err : 1'b0);
         GO = (t == 0) ||
              (noise && t >= 1 && t < a && (x < 0 || t <= x) && $urandom_range(0, 3) == 0) ||
              (go_ack && x < 0 && t == a);
         if (t >= r) begin
            doneA = 1'b1;
            doneB = 1'b1;
         end else begin
            partial = 2'($urandom_range(0, 2));
            doneA   = partial[1];
            doneB   = partial[0];
         end
         comp_done = (t == c) || (level_cd && t >= c && t <= a) ||
                     (noise && t >= arm + 1 && t <= arm + N && $urandom_range(0, 1) == 1);
         ACK        = (t == a);
         ABORT      = (t == x);
         dot_result = 16'($urandom);
         if (t == c) new_res = dot_result;
      end
      if (latch_ok) model_result = new_res;
      if (x != 0) model_err = 1'b0;
   endtask

   initial begin
      int r, c, a, x;
      repeat (3) @(negedge CLK);
      check_all("reset", 1'b0, 1'b0, 0, 1'b0, 1'b0, 16'h0000, 1'b0);
      RST_N = 1'b1;
      @(negedge CLK);
      check_all("post_reset", 1'b0, 1'b0, 0, 1'b0, 1'b0, 16'h0000, 1'b0);

      run_seq("nominal",   0, 10, 15, -1, 1'b0, 1'b0, 1'b0);
      run_seq("late_load", 3, 10, 12, -1, 1'b0, 1'b0, 1'b0);
      run_seq("abort_rd",  0,  8,  9,  3, 1'b0, 1'b0, 1'b0);
      run_seq("abort_cd",  0,  7,  9,  7, 1'b0, 1'b0, 1'b0);
      run_seq("go_stream", 0,  8, 10, -1, 1'b1, 1'b0, 1'b0);
      run_seq("go_ack",    0,  7,  9, -1, 1'b0, 1'b1, 1'b1);
      run_seq("abort_go",  0,  7,  9,  0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset between clock edges during STREAM.
      @(negedge CLK);
      GO = 1'b1; doneA = 1'b1; doneB = 1'b1;
      @(negedge CLK);
      GO = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      check("arst pre RD_EN", 32'(RD_EN), 32'd1);
      check("arst pre ELEM_IDX", 32'(ELEM_IDX), 32'd1);
      #2 RST_N = 1'b0;
      #1 check_all("arst", 1'b0, 1'b0, 0, 1'b0, 1'b0, 16'h0000, 1'b0);
      @(negedge CLK);
      @(negedge CLK);
      RST_N        = 1'b1;
      model_result = '0;
      model_err    = 1'b0;
      run_seq("after_arst", 0, 9, 11, -1, 1'b0, 1'b0, 1'b0);

`ifdef DPSEQ_TIMEOUT_EN
      // comp_done never arrives: WAIT_COMP entered at t=6, expiry 8 cycles later.
      @(negedge CLK);
      GO = 1'b1; doneA = 1'b1; doneB = 1'b1; comp_done = 1'b0;
      for (int t = 1; t <= 16; t++) begin
         @(negedge CLK);
         GO = 1'b0;
         check($sformatf("tmo t%0d BUSY", t), 32'(BUSY), 32'(t <= 13));
         check($sformatf("tmo t%0d ERR", t), 32'(ERR), 32'(t >= 14));
         check($sformatf("tmo t%0d RESULT_VALID", t), 32'(RESULT_VALID), 32'd0);
      end
      model_err = 1'b1;
      run_seq("tmo_clear", 0, 7, 9, -1, 1'b0, 1'b0, 1'b0);
`endif

      for (int k = 0; k < 30; k++) begin
         r = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
         c = r + 1 + N + 1 + int'($urandom_range(0, 4));
         a = c + 1 + int'($urandom_range(0, 4));
         x = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, a)) : -1;
         run_seq($sformatf("rnd%0d", k), r, c, a, x, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
